// File: rtl/sw_input_ctrl.sv
// sw_input_ctrl
// Input-side controller for the CPU's memory-mapped switch ports.
// The ten slide switches are synchronized, debounced as one 10-bit group
// and published on in_port0/in_port1. A valid/ack handshake, an overrun
// flag and an 8-bit update counter are reported on in_port2. Every output
// bit comes straight from a flop, so there is no combinational path from
// sw or cpu_ack to any output.
module sw_input_ctrl #(
    parameter int DB_CYCLES = 50000,
    parameter int CNT_W     = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  sw,
    input  logic        cpu_ack,
    output logic [31:0] in_port0,
    output logic [31:0] in_port1,
    output logic [31:0] in_port2,
    output logic        busy
);

    // Publish handshake states: IDLE = nothing outstanding,
    // WAIT_ACK = a published value has not been acknowledged yet.
    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_ACK = 1'b1
    } state_t;

    // Terminal debounce count: the value is accepted on the clock after
    // the counter has reached DB_CYCLES-1.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // Synchronizer chain; s3 keeps the previous s2 for change detection.
    logic [9:0]       s1_q, s1_d;
    logic [9:0]       s2_q, s2_d;
    logic [9:0]       s3_q, s3_d;

    // Debounce state.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [9:0]       stable_q, stable_d;
    logic             busy_q, busy_d;

    // Publish state.
    state_t           state_q, state_d;
    logic [9:0]       published_q, published_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       count_q, count_d;

    // A newly debounced value that has not yet been driven on the ports.
    logic             new_val_s;

    // Next-state logic for the synchronizer and the debounce counter.
    always_comb begin
        s1_d     = sw;
        s2_d     = s1_q;
        s3_d     = s2_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        if ((s2_q != s3_q) || (s2_q == stable_q)) begin
            // Any bounce, or input already matching stable, restarts the count.
            cnt_d = CNT_ZERO;
        end else if (cnt_q == CNT_LAST) begin
            // Input held long enough: accept it as the new stable value.
            stable_d = s2_q;
            cnt_d    = CNT_ZERO;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
        end
        // busy mirrors "counter not zero" but is kept in its own flop.
        busy_d = (cnt_d != CNT_ZERO);
    end

    // Synchronizer and debounce registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_q     <= 10'd0;
            s2_q     <= 10'd0;
            s3_q     <= 10'd0;
            cnt_q    <= CNT_ZERO;
            stable_q <= 10'd0;
            busy_q   <= 1'b0;
        end else begin
            s1_q     <= s1_d;
            s2_q     <= s2_d;
            s3_q     <= s3_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            busy_q   <= busy_d;
        end
    end

    // Publish FSM: next state and handshake flags.
    always_comb begin
        state_d     = state_q;
        published_d = published_q;
        valid_d     = valid_q;
        overrun_d   = overrun_q;
        count_d     = count_q;
        new_val_s   = (stable_q != published_q);
        case (state_q)
            ST_IDLE: begin
                // cpu_ack is ignored here: nothing is outstanding.
                if (new_val_s) begin
                    published_d = stable_q;
                    valid_d     = 1'b1;
                    count_d     = count_q + 8'd1;
                    state_d     = ST_WAIT_ACK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ACK: begin
                if (new_val_s) begin
                    // New value replaces the unread one. With an ack in the
                    // same cycle the previous value was consumed, so there
                    // is no overrun; without one, it was lost.
                    published_d = stable_q;
                    count_d     = count_q + 8'd1;
                    valid_d     = 1'b1;
                    overrun_d   = !cpu_ack;
                    state_d     = ST_WAIT_ACK;
                end else if (cpu_ack) begin
                    valid_d   = 1'b0;
                    overrun_d = 1'b0;
                    state_d   = ST_IDLE;
                end else begin
                    state_d = ST_WAIT_ACK;
                end
            end
            default: begin
                // Unreachable encoding: fall back to a clean idle.
                state_d     = ST_IDLE;
                published_d = published_q;
                valid_d     = 1'b0;
                overrun_d   = 1'b0;
                count_d     = count_q;
            end
        endcase
    end

    // Publish FSM registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            published_q <= 10'd0;
            valid_q     <= 1'b0;
            overrun_q   <= 1'b0;
            count_q     <= 8'd0;
        end else begin
            state_q     <= state_d;
            published_q <= published_d;
            valid_q     <= valid_d;
            overrun_q   <= overrun_d;
            count_q     <= count_d;
        end
    end

    // Port mapping: every bit is either a flop output or a constant zero.
    assign in_port0 = {27'd0, published_q[9:5]};
    assign in_port1 = {27'd0, published_q[4:0]};
    assign in_port2 = {16'd0, count_q, 6'd0, overrun_q, valid_q};
    assign busy     = busy_q;

endmodule
